// File: rtl/button_events_pkg.sv
// Purpose: shared constants for the push-button conditioner (timing defaults, channel indices).
// Latency: n/a (constants and a helper function only).
// Backpressure: n/a.
package button_events_pkg;

  // Board clock and human-scale timing defaults
  localparam int CLK_HZ      = 100_000_000;
  localparam int DEBOUNCE_MS = 10;
  localparam int LONG_MS     = 1000;
  localparam int REPEAT_MS   = 200;

  // Derived cycle counts at CLK_HZ
  localparam int CYCLES_PER_MS          = CLK_HZ / 1000;
  localparam int DEBOUNCE_CYCLES_DEFAULT = CYCLES_PER_MS * DEBOUNCE_MS;
  localparam int LONG_CYCLES_DEFAULT     = CYCLES_PER_MS * LONG_MS;
  localparam int REPEAT_CYCLES_DEFAULT   = CYCLES_PER_MS * REPEAT_MS;

  // Board button positions on the btn_in bus
  localparam int BTN_U = 0;
  localparam int BTN_C = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  // Larger of two counts, used to size the shared hold/repeat counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_channel.sv
// Purpose: one button channel: 2-FF sync, counter debounce, press/release/long/repeat pulses.
// Latency: btn_raw stable from edge t -> btn_level and press/release pulse at edge t+2+DEBOUNCE_CYCLES.
// Backpressure: none; pulses are one-cycle, fire-and-forget. Macro BUTTON_EVENTS_AUTO_REPEAT_EN adds auto-repeat.
module button_event_channel
  import button_events_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEFAULT,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic          long_done;
  logic          flip;

  // The debounced level changes this cycle: input has disagreed long enough
  assign flip = (sync2 != btn_level) && (deb_cnt == DEB_LAST);

  // Two-stage synchroniser for the asynchronous button input
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Debounce counter; level and edge pulses update together so the pulse lines up with the new level
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt       <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= flip & sync2;
      release_pulse <= flip & ~sync2;
      if (sync2 == btn_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        btn_level <= sync2;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  // Hold counter: a level flip (either way) clears it, so a release always beats a long/repeat threshold
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt   <= '0;
      long_done  <= 1'b0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (!btn_level || flip) begin
        hold_cnt  <= '0;
        long_done <= 1'b0;
      end else if (!long_done) begin
        if (hold_cnt == LONG_LAST) begin
          long_pulse <= 1'b1;
          long_done  <= 1'b1;
`ifdef BUTTON_EVENTS_AUTO_REPEAT_EN
          hold_cnt   <= '0;
`endif
        end else begin
          hold_cnt <= hold_cnt + HW'(1);
        end
      end
`ifdef BUTTON_EVENTS_AUTO_REPEAT_EN
      else if (hold_cnt == HW'(REPEAT_CYCLES - 1)) begin
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + HW'(1);
      end
`endif
      // Without auto-repeat the counter simply saturates once long_done is set
    end
  end

`ifdef BUTTON_EVENTS_AUTO_REPEAT_EN
  logic repeat_q;

  // Repeat tick every REPEAT_CYCLES after the long press, dropped if the button releases that cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      repeat_q <= 1'b0;
    end else begin
      repeat_q <= btn_level && !flip && long_done && (hold_cnt == HW'(REPEAT_CYCLES - 1));
    end
  end

  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/button_events.sv
// Purpose: N-channel push-button conditioner; one independent button_event_channel per bit.
// Latency: input edge to debounced level/pulse is 2+DEBOUNCE_CYCLES clocks; all outputs registered.
// Backpressure: none; outputs are one-cycle pulses. Auto-repeat enabled by BUTTON_EVENTS_AUTO_REPEAT_EN.
module button_events
  import button_events_pkg::*;
#(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEFAULT,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] long_pulse,
  output logic [NUM_BTN-1:0] repeat_pulse
);

  // One channel per button; the top only routes bits
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_event_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .btn_raw      (btn_in[i]),
      .btn_level    (btn_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_events.sv
// Purpose: directed bench for button_events (3 channels, short timings) with an event scoreboard.
// Latency: expected events are scheduled by absolute cycle when stimulus is driven.
// Backpressure: n/a.
module tb_button_events;

  localparam int NB  = 3;
  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 8;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;
  localparam int K_REP   = 3;
  localparam int K_RST   = 4;

  typedef struct {
    int            cyc;
    int            kind;
    logic [NB-1:0] mask;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_in;
  logic [NB-1:0] btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;

  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  ev_t q[$];

  logic [NB-1:0] exp_level = '0;
  logic [NB-1:0] exp_p, exp_r, exp_l, exp_rp;

  button_events #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LNG),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge e (and its NBA region) cyc == e
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input int k, input logic [NB-1:0] m);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.mask = m;
    q.push_back(e);
  endtask

  // Advance to 1 time unit after edge e
  task automatic at(input int e);
    if (cyc >= e) begin
      $display("FAIL schedule: cyc=%0d already past step %0d", cyc, e);
      $fatal(1, "bench schedule error");
    end
    while (cyc != e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: pop every event due this cycle and compare all outputs
  always @(negedge clk) begin
    if (cyc >= 1) begin
      exp_p  = '0;
      exp_r  = '0;
      exp_l  = '0;
      exp_rp = '0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc == cyc) begin
          case (q[i].kind)
            K_PRESS: begin exp_p |= q[i].mask; exp_level |= q[i].mask; end
            K_REL:   begin exp_r |= q[i].mask; exp_level &= ~q[i].mask; end
            K_LONG:  exp_l  |= q[i].mask;
            K_REP:   exp_rp |= q[i].mask;
            default: exp_level = '0;
          endcase
          q.delete(i);
        end
      end
      vectors++;
      assert (btn_level === exp_level) else begin
        miscompares++;
        $error("FAIL level cyc=%0d got=%b exp=%b", cyc, btn_level, exp_level);
      end
      vectors++;
      assert (press_pulse === exp_p) else begin
        miscompares++;
        $error("FAIL press cyc=%0d got=%b exp=%b", cyc, press_pulse, exp_p);
      end
      vectors++;
      assert (release_pulse === exp_r) else begin
        miscompares++;
        $error("FAIL release cyc=%0d got=%b exp=%b", cyc, release_pulse, exp_r);
      end
      vectors++;
      assert (long_pulse === exp_l) else begin
        miscompares++;
        $error("FAIL long cyc=%0d got=%b exp=%b", cyc, long_pulse, exp_l);
      end
      vectors++;
      assert (repeat_pulse === exp_rp) else begin
        miscompares++;
        $error("FAIL repeat cyc=%0d got=%b exp=%b", cyc, repeat_pulse, exp_rp);
      end
    end
  end

  initial begin
    // Reset held 3 cycles with all buttons down: nothing until 6 cycles after deassert
    reset  = 1'b1;
    btn_in = 3'b111;
    at(3);   reset = 1'b0;             push(9, K_PRESS, 3'b111);
    at(12);  btn_in = 3'b000;          push(18, K_REL, 3'b111);

    // Glitch on channel 0: 3 cycles high is one short of the debounce threshold
    at(25);  btn_in[0] = 1'b1;
    at(28);  btn_in[0] = 1'b0;

    // Clean short press on channel 1
    at(40);  btn_in[1] = 1'b1;         push(46, K_PRESS, 3'b010);
    at(55);  btn_in[1] = 1'b0;         push(61, K_REL, 3'b010);

    // Release lands exactly on the long threshold: release only
    at(80);  btn_in[1] = 1'b1;         push(86, K_PRESS, 3'b010);
    at(100); btn_in[1] = 1'b0;         push(106, K_REL, 3'b010);

    // Release one cycle after the long threshold: long then release
    at(120); btn_in[1] = 1'b1;         push(126, K_PRESS, 3'b010);
                                       push(146, K_LONG, 3'b010);
    at(141); btn_in[1] = 1'b0;         push(147, K_REL, 3'b010);

    // Long press on channel 2, held 60 cycles
    at(160); btn_in[2] = 1'b1;         push(166, K_PRESS, 3'b100);
                                       push(186, K_LONG, 3'b100);
`ifdef BUTTON_EVENTS_AUTO_REPEAT_EN
    for (int k = 1; k <= 4; k++) push(186 + k * REP, K_REP, 3'b100);
`endif
    at(220); btn_in[2] = 1'b0;         push(226, K_REL, 3'b100);

    // Simultaneous: 0 and 2 pressed while 1 released in the same cycle
    at(240); btn_in = 3'b010;          push(246, K_PRESS, 3'b010);
    at(260); btn_in = 3'b101;          push(266, K_PRESS, 3'b101);
                                       push(266, K_REL, 3'b010);
    at(275); btn_in = 3'b000;          push(281, K_REL, 3'b101);

    // Reset for one cycle mid-hold (hold count 15) on channel 0
    at(290); btn_in[0] = 1'b1;         push(296, K_PRESS, 3'b001);
    at(311); reset = 1'b1;             push(312, K_RST, 3'b000);
    at(312); reset = 1'b0;             push(318, K_PRESS, 3'b001);
                                       push(338, K_LONG, 3'b001);
`ifdef BUTTON_EVENTS_AUTO_REPEAT_EN
                                       push(346, K_REP, 3'b001);
`endif
    at(345); btn_in[0] = 1'b0;         push(351, K_REL, 3'b001);

    at(365);
    vectors++;
    assert (q.size() === 0) else begin
      miscompares++;
      $error("FAIL pending_events got=%0d exp=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
